mic_read_ctrl: RTL and testbench
================================

MIC_READ_CTRL -- requirements
Module: mic_read_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of mem_rdata and read_data.
REQ-002 The block SHALL have parameter ADDR_W, default 16, giving the address width.
REQ-003 The block SHALL have parameter MAX_LEN, default 16, giving the maximum number of beats per burst.
REQ-004 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of WAIT cycles per beat.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: the reset, which is synchronous and active-high.
REQ-007 The block SHALL have port req_valid, input, 1 bit: burst request valid.
REQ-008 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits: burst start address.
REQ-010 The block SHALL have port req_len, input, LEN_W bits: beat count minus 1, where LEN_W = $clog2(MAX_LEN).
REQ-011 The block SHALL have port mem_rd_en, output, 1 bit: memory read strobe.
REQ-012 The block SHALL have port mem_addr, output, ADDR_W bits: memory read address.
REQ-013 The block SHALL have port mem_rdata, input, WIDTH bits: memory read data.
REQ-014 The block SHALL have port mem_ack, input, 1 bit: mem_rdata is valid this cycle.
REQ-015 The block SHALL have port read_data, output, WIDTH bits: beat data for the downstream capture register.
REQ-016 The block SHALL have port read_valid, output, 1 bit: read_data is valid, as a one-cycle pulse per beat.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes normally.
REQ-018 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a burst is aborted by timeout.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and ABORT.
REQ-020 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a cycle with req_valid && req_ready.
REQ-021 On acceptance, the block SHALL register req_addr and req_len, clear the beat counter and go to ISSUE.
REQ-022 In ISSUE, the block SHALL drive mem_rd_en=1 with mem_addr set to the current address for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-023 mem_ack SHALL be ignored in IDLE, ISSUE and ABORT.
REQ-024 In WAIT with mem_ack=1, the block SHALL register mem_rdata into read_data and assert read_valid on the following cycle for one cycle.
REQ-025 read_valid SHALL therefore lag the mem_ack sample by 1 cycle.
REQ-026 After an acked beat, if beat count < len, the block SHALL increment address and beat count and return to ISSUE; otherwise it SHALL pulse done (aligned with the last read_valid) and return to IDLE.
REQ-027 The address SHALL increment modulo 2^ADDR_W, so 0xFFFF + 1 = 0x0000 at the default width.
REQ-028 In WAIT with mem_ack=0, the timeout counter SHALL increment.
REQ-029 When the timeout counter reaches TIMEOUT-1 with no ack, the block SHALL go to ABORT.
REQ-030 If mem_ack and the timeout condition occur on the same cycle, mem_ack SHALL win and no error is raised.
REQ-031 ABORT SHALL last one cycle, pulse timeout_err, drop any remaining beats without a done pulse, and return to IDLE.
REQ-032 read_data SHALL hold its last captured value until the next acked beat, and SHALL never change in a cycle without a preceding ack.
REQ-033 Minimum beat period SHALL be 2 cycles (ISSUE then WAIT with immediate ack).
REQ-034 At most one memory read SHALL be outstanding at any time.

Reset
REQ-035 While reset=1 at a clock edge, the state SHALL be IDLE and read_data, the registered address, the length register and all counters SHALL be 0.
REQ-036 While reset=1 at a clock edge, mem_rd_en, read_valid, done and timeout_err SHALL be 0, and req_ready SHALL be 1 from the first cycle after reset is released.
REQ-037 Reset mid-burst SHALL abandon the burst with no done or timeout_err pulse, and mem_rd_en SHALL be low on the cycle following the reset edge.

Structure
REQ-038 The state enum (IDLE, ISSUE, WAIT, ABORT) and the default parameter constants SHALL live in shared package mic_pkg.
REQ-039 The timeout counter SHALL be sub-module mic_timeout_cnt (inputs clear/enable, output expired), and everything else SHALL be inline.
REQ-040 The block SHALL feed the downstream capture register directly via read_data and read_valid with no glue logic.

Verification
REQ-041 The bench SHALL cover a single beat: req_addr=0x0010, req_len=0, ack 1 cycle after mem_rd_en with rdata=0xDEADBEEF -> read_valid with 0xDEADBEEF 1 cycle later, done together with it, req_ready back high.
REQ-042 The bench SHALL cover a 4-beat burst: addr=0x0100, len=3, acks after 0/2/5/1 WAIT cycles -> mem_addr sequence 0x100..0x103, four read_valid pulses in order, one done.
REQ-043 The bench SHALL cover wrap-around: addr=0xFFFE, len=3 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-044 The bench SHALL cover timeout: len=1, first beat never acked -> timeout_err pulse after TIMEOUT WAIT cycles, no read_valid, no done, second beat not issued.
REQ-045 The bench SHALL cover ack on the final timeout cycle -> beat accepted, no timeout_err.
REQ-046 The bench SHALL cover reset mid-burst: reset asserted during WAIT of beat 2 of 4 -> all outputs at reset values next cycle, a later ack is ignored, and a new request is accepted normally.

Source files
------------

// File: rtl/mic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mic_pkg
// Purpose  : Shared state encoding and default parameters for the memory
//            interface read controller.
// Revision : 1.0 - initial release
// ============================================================================
package mic_pkg;

  // Default parameter values for mic_read_ctrl
  localparam int unsigned MIC_WIDTH   = 32;
  localparam int unsigned MIC_ADDR_W  = 16;
  localparam int unsigned MIC_MAX_LEN = 16;
  localparam int unsigned MIC_TIMEOUT = 64;

  // Burst read controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ABORT = 2'd3
  } mic_state_t;

endpackage : mic_pkg
`default_nettype wire

// File: rtl/mic_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mic_timeout_cnt
// Purpose  : Per-beat wait counter. Flags expiry once it has counted
//            TIMEOUT-1 unacknowledged wait cycles; saturates there.
// Revision : 1.0 - initial release
// ============================================================================
module mic_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count wait cycles; hold at the terminal value so it can never wrap
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = (r_cnt == LAST);

endmodule : mic_timeout_cnt
`default_nettype wire

// File: rtl/mic_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mic_read_ctrl
// Purpose  : Burst read controller. Accepts a start address and beat count,
//            issues one memory read per beat (one outstanding at a time),
//            forwards each acknowledged beat downstream and aborts a burst
//            whose memory fails to answer within TIMEOUT wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mic_read_ctrl
  import mic_pkg::*;
#(
  parameter  int WIDTH   = MIC_WIDTH,
  parameter  int ADDR_W  = MIC_ADDR_W,
  parameter  int MAX_LEN = MIC_MAX_LEN,
  parameter  int TIMEOUT = MIC_TIMEOUT,
  localparam int LEN_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              clock,
  input  logic              reset,
  // Burst request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  // Memory read port
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  // Downstream beat data and status
  output logic [WIDTH-1:0]  read_data,
  output logic              read_valid,
  output logic              done,
  output logic              timeout_err
);

  mic_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat;
  logic [WIDTH-1:0]  r_read_data;
  logic              r_read_valid;
  logic              r_done;
  logic              r_timeout_err;
  logic              r_mem_rd_en;

  logic              w_tmo_clear;
  logic              w_tmo_enable;
  logic              w_tmo_expired;

  // The wait counter restarts with every issued beat and only advances
  // on wait cycles that see no acknowledge.
  assign w_tmo_clear  = (r_state == ISSUE);
  assign w_tmo_enable = (r_state == WAIT) && !mem_ack;

  mic_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_tmo_clear),
    .enable  (w_tmo_enable),
    .expired (w_tmo_expired)
  );

  // Burst sequencing FSM with registered strobes and beat capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_read_data   <= '0;
      r_read_valid  <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_mem_rd_en   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below
      r_read_valid  <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_mem_rd_en   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_len       <= req_len;
            r_beat      <= '0;
            r_mem_rd_en <= 1'b1;
            r_state     <= ISSUE;
          end
        end

        ISSUE: begin
          r_state <= WAIT;
        end

        WAIT: begin
          // An acknowledge on the expiry cycle still counts as a good beat
          if (mem_ack) begin
            r_read_data  <= mem_rdata;
            r_read_valid <= 1'b1;
            if (r_beat < r_len) begin
              r_addr      <= r_addr + ADDR_W'(1);
              r_beat      <= r_beat + LEN_W'(1);
              r_mem_rd_en <= 1'b1;
              r_state     <= ISSUE;
            end else begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end else if (w_tmo_expired) begin
            r_timeout_err <= 1'b1;
            r_state       <= ABORT;
          end
        end

        ABORT: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_addr    = r_addr;
  assign read_data   = r_read_data;
  assign read_valid  = r_read_valid;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;

endmodule : mic_read_ctrl
`default_nettype wire

// File: tb/tb_mic_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic_read_ctrl
// Purpose  : Directed self-checking bench for mic_read_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mic_read_ctrl;

  localparam int TMO = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [3:0]  req_len;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] read_data;
  logic        read_valid;
  logic        done;
  logic        timeout_err;

  int n_vec = 0;
  int n_err = 0;

  mic_read_ctrl #(
    .WIDTH   (32),
    .ADDR_W  (16),
    .MAX_LEN (16),
    .TIMEOUT (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .done        (done),
    .timeout_err (timeout_err)
  );

  // 100 MHz clock
  always #5 clock = ~clock;

  // Advance one clock; sample and drive 1 ns after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({mem_rd_en, read_valid, done, timeout_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_strobes: got rd_en/rv/done/tmo=%b expected 0000",
               {mem_rd_en, read_valid, done, timeout_err});
    end
    n_vec++;
    if (read_data !== 32'h0 || mem_addr !== 16'h0) begin
      n_err++;
      $display("FAIL reset_regs: got read_data=%h mem_addr=%h expected 0/0", read_data, mem_addr);
    end
    reset = 1'b0;
    tick();
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_single();
    req_valid = 1'b1;
    req_addr  = 16'h0010;
    req_len   = 4'd0;
    tick();
    req_valid = 1'b0;
    n_vec++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0010 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_issue: got rd_en=%b addr=%h ready=%b expected 1/0010/0",
               mem_rd_en, mem_addr, req_ready);
    end
    tick();
    n_vec++;
    if (mem_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL single_strobe_len: got rd_en=%b in wait expected 0", mem_rd_en);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    n_vec++;
    if (read_valid !== 1'b1 || read_data !== 32'hDEADBEEF || done !== 1'b1 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_beat: got rv=%b data=%h done=%b ready=%b expected 1/deadbeef/1/1",
               read_valid, read_data, done, req_ready);
    end
    tick();
    n_vec++;
    if (read_valid !== 1'b0 || done !== 1'b0 || read_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL single_after: got rv=%b done=%b data=%h expected 0/0/deadbeef",
               read_valid, done, read_data);
    end
  endtask

  task automatic test_burst4();
    int          dly [4] = '{0, 2, 5, 1};
    logic [15:0] exp_addr;
    logic [31:0] exp_data;
    int          n_rv;
    int          n_done;
    n_rv   = 0;
    n_done = 0;
    req_valid = 1'b1;
    req_addr  = 16'h0100;
    req_len   = 4'd3;
    tick();
    req_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_addr = 16'h0100 + 16'(b);
      exp_data = 32'hA5A5_0000 + 32'(b);
      n_vec++;
      if (mem_rd_en !== 1'b1 || mem_addr !== exp_addr) begin
        n_err++;
        $display("FAIL burst4_issue%0d: got rd_en=%b addr=%h expected 1/%h", b, mem_rd_en, mem_addr, exp_addr);
      end
      tick();
      for (int w = 0; w < dly[b]; w++) begin
        n_rv   += int'(read_valid);
        n_done += int'(done);
        tick();
      end
      mem_ack   = 1'b1;
      mem_rdata = exp_data;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      n_rv   += int'(read_valid);
      n_done += int'(done);
      n_vec++;
      if (read_valid !== 1'b1 || read_data !== exp_data || done !== (b == 3)) begin
        n_err++;
        $display("FAIL burst4_beat%0d: got rv=%b data=%h done=%b expected 1/%h/%b",
                 b, read_valid, read_data, done, exp_data, (b == 3));
      end
    end
    tick();
    n_vec++;
    if (n_rv !== 4 || n_done !== 1 || req_ready !== 1'b1 || mem_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL burst4_totals: got rv=%0d done=%0d ready=%b rd_en=%b expected 4/1/1/0",
               n_rv, n_done, req_ready, mem_rd_en);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_addr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    req_valid = 1'b1;
    req_addr  = 16'hFFFE;
    req_len   = 4'd3;
    tick();
    req_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      n_vec++;
      if (mem_rd_en !== 1'b1 || mem_addr !== exp_addr[b]) begin
        n_err++;
        $display("FAIL wrap_addr%0d: got rd_en=%b addr=%h expected 1/%h", b, mem_rd_en, mem_addr, exp_addr[b]);
      end
      tick();
      mem_ack   = 1'b1;
      mem_rdata = 32'h5A00_0000 + 32'(b);
      tick();
      mem_ack   = 1'b0;
    end
    n_vec++;
    if (done !== 1'b1 || read_data !== 32'h5A00_0003) begin
      n_err++;
      $display("FAIL wrap_done: got done=%b data=%h expected 1/5a000003", done, read_data);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n_rv;
    int n_done;
    int n_rd;
    int n_early;
    n_rv = 0; n_done = 0; n_rd = 0; n_early = 0;
    req_valid = 1'b1;
    req_addr  = 16'h0200;
    req_len   = 4'd1;
    tick();
    req_valid = 1'b0;
    tick();
    // now in wait cycle 1; cycles 1..TMO-1 must stay quiet
    for (int c = 1; c < TMO; c++) begin
      n_early += int'(timeout_err);
      n_rv    += int'(read_valid);
      n_done  += int'(done);
      n_rd    += int'(mem_rd_en);
      tick();
    end
    n_early += int'(timeout_err);
    n_vec++;
    if (n_early !== 0) begin
      n_err++;
      $display("FAIL timeout_early: got %0d early timeout_err cycles expected 0", n_early);
    end
    tick();
    n_vec++;
    if (timeout_err !== 1'b1 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_pulse: got tmo=%b ready=%b expected 1/0", timeout_err, req_ready);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_rv   += int'(read_valid);
      n_done += int'(done);
      n_rd   += int'(mem_rd_en);
      n_early += int'(timeout_err);
    end
    n_vec++;
    if (n_rv !== 0 || n_done !== 0 || n_rd !== 0 || n_early !== 0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_quiet: got rv=%0d done=%0d rd_en=%0d tmo_extra=%0d ready=%b expected 0/0/0/0/1",
               n_rv, n_done, n_rd, n_early, req_ready);
    end
  endtask

  task automatic test_ack_last();
    req_valid = 1'b1;
    req_addr  = 16'h0300;
    req_len   = 4'd0;
    tick();
    req_valid = 1'b0;
    tick();
    for (int c = 1; c < TMO; c++) tick();
    // wait cycle TMO: the final one before abort
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack   = 1'b0;
    n_vec++;
    if (read_valid !== 1'b1 || read_data !== 32'h1234_5678 || done !== 1'b1 || timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL ack_last: got rv=%b data=%h done=%b tmo=%b expected 1/12345678/1/0",
               read_valid, read_data, done, timeout_err);
    end
    tick();
    n_vec++;
    if (timeout_err !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ack_last_after: got tmo=%b ready=%b expected 0/1", timeout_err, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1;
    req_addr  = 16'h0400;
    req_len   = 4'd3;
    tick();
    req_valid = 1'b0;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0001;
    tick();
    mem_ack   = 1'b0;
    n_vec++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0401) begin
      n_err++;
      $display("FAIL rstmid_beat2: got rd_en=%b addr=%h expected 1/0401", mem_rd_en, mem_addr);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if ({mem_rd_en, read_valid, done, timeout_err} !== 4'b0000 || read_data !== 32'h0 ||
        mem_addr !== 16'h0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_outputs: got strobes=%b data=%h addr=%h ready=%b expected 0000/0/0/1",
               {mem_rd_en, read_valid, done, timeout_err}, read_data, mem_addr, req_ready);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack   = 1'b0;
    n_vec++;
    if (read_valid !== 1'b0 || read_data !== 32'h0 || mem_rd_en !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_late_ack: got rv=%b data=%h rd_en=%b done=%b expected 0/0/0/0",
               read_valid, read_data, mem_rd_en, done);
    end
    req_valid = 1'b1;
    req_addr  = 16'h0500;
    req_len   = 4'd0;
    tick();
    req_valid = 1'b0;
    n_vec++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0500) begin
      n_err++;
      $display("FAIL rstmid_new_issue: got rd_en=%b addr=%h expected 1/0500", mem_rd_en, mem_addr);
    end
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack   = 1'b0;
    n_vec++;
    if (read_valid !== 1'b1 || read_data !== 32'hCAFE_F00D || done !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_new_beat: got rv=%b data=%h done=%b expected 1/cafef00d/1",
               read_valid, read_data, done);
    end
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 16'h0;
    req_len   = 4'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    test_reset();
    test_single();
    test_burst4();
    test_wrap();
    test_timeout();
    test_ack_last();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Run-time bound in case the bench stalls
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_mic_read_ctrl
`default_nettype wire
